// File: rtl/mul4_rr_scheduler.sv
// Round-robin scheduler that shares one NAND-built 4x4 multiplier among four requesters.
// An accepted request moves through IDLE -> CALC -> HOLD and is held on the response port until the consumer takes it.
module mul4_nand (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  function automatic logic nd(input logic x, input logic y);
    return ~(x & y);
  endfunction

  function automatic logic and2(input logic x, input logic y);
    return nd(nd(x, y), nd(x, y));
  endfunction

  // Nine-gate NAND full adder; returns {carry, sum}
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    logic n1, n2, n3, xo, n5, n6, n7;
    n1 = nd(x, y);
    n2 = nd(x, n1);
    n3 = nd(y, n1);
    xo = nd(n2, n3);
    n5 = nd(xo, ci);
    n6 = nd(xo, n5);
    n7 = nd(ci, n5);
    return {nd(n1, n5), nd(n6, n7)};
  endfunction

  // Array multiplier: each row adds the next partial product to the shifted running sum
  always_comb begin : arr
    logic [3:0] acc, pp, sh;
    logic       cy, c;
    logic [1:0] r;
    p  = '0;
    pp = '0;
    sh = '0;
    r  = '0;
    c  = 1'b0;
    cy = 1'b0;
    for (int j = 0; j < 4; j++) acc[j] = and2(a[j], b[0]);
    p[0] = acc[0];
    for (int i = 1; i < 4; i++) begin
      sh = {cy, acc[3:1]};
      c  = 1'b0;
      for (int j = 0; j < 4; j++) begin
        pp[j]  = and2(a[j], b[i]);
        r      = fa(sh[j], pp[j], c);
        acc[j] = r[0];
        c      = r[1];
      end
      cy   = c;
      p[i] = acc[0];
    end
    p[7:4] = {cy, acc[3:1]};
  end
endmodule

module mul4_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int RR_INIT = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [1:0]        resp_id,
  output logic [7:0]        resp_p,
  input  logic              resp_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);
  localparam int IW = 2;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr, id_reg, gnt_id;
  logic            gnt_any;
  logic [3:0]      op_a, op_b;
  logic [7:0]      prod;

  mul4_nand u_mul (.a(op_a), .b(op_b), .p(prod));

  // Scan downward so the requester closest to rr_ptr wins
  always_comb begin : pick
    logic [IW-1:0] idx;
    gnt_any = 1'b0;
    gnt_id  = rr_ptr;
    idx     = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = rr_ptr + IW'(k);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_any) req_ready[gnt_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= IW'(RR_INIT);
      id_reg     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_p     <= '0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          op_a   <= req_a[4*gnt_id +: 4];
          op_b   <= req_b[4*gnt_id +: 4];
          id_reg <= gnt_id;
          rr_ptr <= gnt_id + IW'(1);
          state  <= CALC;
        end
        CALC: begin
          resp_p     <= prod;
          resp_id    <= id_reg;
          resp_valid <= 1'b1;
          state      <= HOLD;
        end
        HOLD: if (resp_ready) begin
          resp_valid <= 1'b0;
          done_cnt   <= done_cnt + CNT_W'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul4_rr_scheduler.sv
// Bench for mul4_rr_scheduler: vector table, round-robin/backpressure/reset sequences,
// and a scoreboard fed by every observed grant and drained on every response handshake.
module tb_mul4_rr_scheduler;
  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic        resp_valid, resp_ready, busy;
  logic [1:0]  resp_id;
  logic [7:0]  resp_p, done_cnt;

  mul4_rr_scheduler #(.NREQ(4), .RR_INIT(0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_p(resp_p),
    .resp_ready(resp_ready), .busy(busy), .done_cnt(done_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [1:0] id; logic [7:0] p; } sb_t;
  typedef struct { int id; int a; int b; int p; } vec_t;

  sb_t  exp_q[$];
  int   checks = 0, errors = 0;
  int   mdl_ptr = 0, mdl_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", nm, $time);
  endtask

  // Scoreboard and independent round-robin model
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      mdl_ptr = 0;
      mdl_cnt = 0;
    end else begin
      if (resp_valid && resp_ready) begin
        chk("done_cnt", {24'b0, done_cnt}, mdl_cnt % 256);
        if (exp_q.size() == 0) timeout("sb_underflow");
        else begin
          sb_t e;
          e = exp_q.pop_front();
          chk("sb_id", {30'b0, resp_id}, {30'b0, e.id});
          chk("sb_p", {24'b0, resp_p}, {24'b0, e.p});
        end
        mdl_cnt++;
      end
      if (req_ready != 4'b0) begin
        int g;
        g = -1;
        for (int k = 0; k < 4; k++)
          if (g < 0 && req_valid[(mdl_ptr + k) % 4]) g = (mdl_ptr + k) % 4;
        chk("grant", {28'b0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
          sb_t e;
          e.id = 2'(g);
          e.p  = 8'(req_a[4*g +: 4]) * 8'(req_b[4*g +: 4]);
          exp_q.push_back(e);
          mdl_ptr = (g + 1) % 4;
        end
      end
    end
  end

  task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b);
    bit got;
    @(posedge clk); #1;
    req_a[4*id +: 4] = a;
    req_b[4*id +: 4] = b;
    req_valid[id]    = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
    end
    if (!got) timeout("issue_grant");
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (!busy && !resp_valid) ok = 1;
    end
    if (!ok) timeout("wait_idle");
  endtask

  vec_t vecs[5];

  initial begin
    int n, np, cyc;
    bit got;
    int pc[4];
    logic [3:0] pv[4];

    vecs[0] = '{2, 13, 11, 143};
    vecs[1] = '{0, 15, 15, 225};
    vecs[2] = '{1, 0, 15, 0};
    vecs[3] = '{3, 15, 1, 15};
    vecs[4] = '{2, 1, 1, 1};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("reset_idle", {busy, resp_valid, req_ready, done_cnt}, 32'd0);
    end

    // Table: single requests with fixed expected products and latency
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].id, 4'(vecs[i].a), 4'(vecs[i].b));
      @(negedge clk);
      chk("ready_pulse", {28'b0, req_ready}, 32'd0);
      n = 1; got = 0;
      while (!got && n < 10) begin
        if (resp_valid) got = 1;
        else begin @(negedge clk); n++; end
      end
      if (!got) timeout("tbl_resp");
      chk("tbl_latency", n, 2);
      chk("tbl_id", {30'b0, resp_id}, vecs[i].id);
      chk("tbl_p", {24'b0, resp_p}, vecs[i].p);
      @(negedge clk);
      chk("tbl_done_cnt", {24'b0, done_cnt}, i + 1);
    end

    // Round-robin with all four requesting continuously
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[4*i +: 4] = 4'(i * 3);
      req_b[4*i +: 4] = 4'(i + 2);
    end
    req_valid = 4'hF;
    np = 0; cyc = 0;
    while (np < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_ready != 4'b0) begin
        pc[np] = cyc;
        pv[np] = req_ready;
        np++;
      end
    end
    if (np < 4) timeout("rr_pulses");
    for (int i = 0; i < np; i++) chk("rr_order", {28'b0, pv[i]}, 32'd1 << i);
    for (int i = 1; i < np; i++) chk("rr_spacing", pc[i] - pc[i-1], 3);

    // Backpressure on requester 3's response (9*5 = 45)
    @(posedge clk); #1 resp_ready = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    if (!got) timeout("bp_resp");
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_hold", {17'b0, resp_valid, resp_id, resp_p, busy, req_ready},
          {17'b0, 1'b1, 2'd3, 8'd45, 1'b1, 4'b0000});
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("grant_after_hs", {28'b0, req_ready}, 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Exhaustive operand sweep through requester 3
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        issue(3, 4'(a), 4'(b));
        wait_idle();
      end

    // Async reset while a response is held
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; resp_ready = 1'b0;
    issue(1, 4'd5, 4'd7);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    if (!got) timeout("hold_resp");
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("async_rst", {resp_valid, busy, done_cnt}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) got = 1;
    end
    if (!got) timeout("post_rst_grant");
    chk("post_rst_grant", {28'b0, req_ready}, 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
